// File: rtl/mil1553_pkg.sv
// Purpose: shared types and constants for the 1553 transmit arbiter slice.
// Latency: n/a (types, constants and a gap-length helper only).
// Backpressure: n/a.
package mil1553_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_XFER = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // tuser[0] selects the sync pattern the encoder emits for the word.
   localparam logic TUSER_CMD_SYNC  = 1'b1;
   localparam logic TUSER_DATA_SYNC = 1'b0;

   // 1 command word + 32 data words.
   localparam int MAX_WORDS_DEF = 33;

   // Inter-message gap length in aclk cycles.
   function automatic int gap_cycles(input int clk_hz, input int gap_us);
      return (clk_hz / 1000000) * gap_us;
   endfunction

endpackage

// File: rtl/mil1553_gap_timer.sv
// Purpose: down-counter timing the idle gap between two granted messages.
// Latency: done drops the cycle after load; it rises GAP_CYCLES-1 counting cycles later.
// Backpressure: none; count is ignored once the counter has reached zero.
// Ports: aclk/arstn clock and async active-low reset; load presets the counter to
//        GAP_CYCLES-1; count decrements it; done is high while the counter is zero.
module mil1553_gap_timer #(
   parameter int GAP_CYCLES = 200
) (
   input  logic aclk,
   input  logic arstn,
   input  logic load,
   input  logic count,
   output logic done
);

   localparam int            CW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

   logic [CW-1:0] cnt;

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/mil1553_tx_arbiter.sv
// Purpose: grants the single 1553 encoder input to one of two word streams, whole
//          messages at a time, round-robin, with a timed idle gap after each message.
// Latency: first word reaches m_* 2 cycles after tvalid rises; XFER is a combinational pass-through.
// Backpressure: granted s*_tready follows m_tready; ungranted and in-gap tready are held 0.
// Ports: aclk/arstn; s0_*/s1_* requester word streams (tdata, tuser, tlast, tvalid, tready);
//        m_* encoder stream; grant (one-hot), busy, err_overlen / err_sync single-cycle pulses.
module mil1553_tx_arbiter
   import mil1553_pkg::*;
#(
   parameter int CLOCK_SPEED = 50000000,
   parameter int GAP_US      = 4,
   parameter int MAX_WORDS   = MAX_WORDS_DEF
) (
   input  logic        aclk,
   input  logic        arstn,
   input  logic [15:0] s0_tdata,
   input  logic [7:0]  s0_tuser,
   input  logic        s0_tlast,
   input  logic        s0_tvalid,
   output logic        s0_tready,
   input  logic [15:0] s1_tdata,
   input  logic [7:0]  s1_tuser,
   input  logic        s1_tlast,
   input  logic        s1_tvalid,
   output logic        s1_tready,
   output logic [15:0] m_tdata,
   output logic [7:0]  m_tuser,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        err_overlen,
   output logic        err_sync
);

   localparam int            GAP_CYCLES = gap_cycles(CLOCK_SPEED, GAP_US);
   localparam int            CW         = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam logic [CW-1:0] LAST_IDX   = CW'(MAX_WORDS - 1);

   state_t        state;
   logic [1:0]    grant_q;
   logic          busy_q;
   logic          ptr;        // channel that wins when both requesters are valid
   logic [CW-1:0] count;      // words handshaken in the current grant

   logic [15:0]   sel_data;
   logic [7:0]    sel_user;
   logic          sel_last;
   logic          sel_vld;
   logic          hs;
   logic          at_cap;
   logic          msg_end;
   logic          gap_load;
   logic          gap_done;

   // Granted-channel mux; everything reads as zero without a grant.
   always_comb begin
      sel_data = '0;
      sel_user = '0;
      sel_last = 1'b0;
      sel_vld  = 1'b0;
      case (grant_q)
         2'b01: begin
            sel_data = s0_tdata;
            sel_user = s0_tuser;
            sel_last = s0_tlast;
            sel_vld  = s0_tvalid;
         end
         2'b10: begin
            sel_data = s1_tdata;
            sel_user = s1_tuser;
            sel_last = s1_tlast;
            sel_vld  = s1_tvalid;
         end
         default: ;
      endcase
   end

   assign m_tdata   = sel_data;
   assign m_tuser   = sel_user;
   assign m_tvalid  = sel_vld;
   assign s0_tready = grant_q[0] & m_tready;
   assign s1_tready = grant_q[1] & m_tready;
   assign grant     = grant_q;
   assign busy      = busy_q;

   assign hs      = sel_vld & m_tready;
   assign at_cap  = (count == LAST_IDX);
   // A message closes on tlast or when the word cap is hit; leftover words
   // from the requester become a fresh message at the next arbitration.
   assign msg_end = hs & (sel_last | at_cap);

   assign err_sync    = hs & (count == '0) & (sel_user[0] == TUSER_DATA_SYNC);
   assign err_overlen = hs & at_cap & ~sel_last;

   assign gap_load = (state == ST_XFER) & msg_end;

   mil1553_gap_timer #(
      .GAP_CYCLES (GAP_CYCLES)
   ) u_gap_timer (
      .aclk  (aclk),
      .arstn (arstn),
      .load  (gap_load),
      .count (state == ST_GAP),
      .done  (gap_done)
   );

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state   <= ST_IDLE;
         grant_q <= 2'b00;
         busy_q  <= 1'b0;
         ptr     <= 1'b0;
         count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (s0_tvalid || s1_tvalid) begin
                  state  <= ST_ARB;
                  busy_q <= 1'b1;
               end
            end
            ST_ARB: begin
               if (s0_tvalid && s1_tvalid) begin
                  grant_q <= ptr ? 2'b10 : 2'b01;
                  state   <= ST_XFER;
               end else if (s0_tvalid) begin
                  grant_q <= 2'b01;
                  state   <= ST_XFER;
               end else if (s1_tvalid) begin
                  grant_q <= 2'b10;
                  state   <= ST_XFER;
               end else begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            ST_XFER: begin
               if (msg_end) begin
                  grant_q <= 2'b00;
                  count   <= '0;
                  ptr     <= grant_q[0];   // hand priority to the other channel
                  if (GAP_CYCLES == 0) begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     state <= ST_GAP;
                  end
               end else if (hs) begin
                  count <= count + CW'(1);
               end
            end
            ST_GAP: begin
               if (gap_done) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               grant_q <= 2'b00;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mil1553_tx_arbiter.sv
`timescale 1ns/1ps
module tb_mil1553_tx_arbiter;
   import mil1553_pkg::*;

   localparam int CLOCK_SPEED = 50000000;
   localparam int GAP_US      = 4;
   localparam int MAX_WORDS   = 33;
   localparam int GAP_CYCLES  = (CLOCK_SPEED / 1000000) * GAP_US;

   logic        aclk  = 1'b0;
   logic        arstn = 1'b1;
   logic [15:0] s0_tdata, s1_tdata;
   logic [7:0]  s0_tuser, s1_tuser;
   logic        s0_tlast, s1_tlast;
   logic        s0_tvalid, s1_tvalid;
   logic        s0_tready, s1_tready;
   logic [15:0] m_tdata;
   logic [7:0]  m_tuser;
   logic        m_tvalid;
   logic        m_tready;
   logic [1:0]  grant;
   logic        busy;
   logic        err_overlen;
   logic        err_sync;

   always #10 aclk = ~aclk;

   mil1553_tx_arbiter #(
      .CLOCK_SPEED (CLOCK_SPEED),
      .GAP_US      (GAP_US),
      .MAX_WORDS   (MAX_WORDS)
   ) dut (
      .aclk        (aclk),
      .arstn       (arstn),
      .s0_tdata    (s0_tdata),
      .s0_tuser    (s0_tuser),
      .s0_tlast    (s0_tlast),
      .s0_tvalid   (s0_tvalid),
      .s0_tready   (s0_tready),
      .s1_tdata    (s1_tdata),
      .s1_tuser    (s1_tuser),
      .s1_tlast    (s1_tlast),
      .s1_tvalid   (s1_tvalid),
      .s1_tready   (s1_tready),
      .m_tdata     (m_tdata),
      .m_tuser     (m_tuser),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .grant       (grant),
      .busy        (busy),
      .err_overlen (err_overlen),
      .err_sync    (err_sync)
   );

   // One expected encoder-side word: grant it appears under, payload, error pulses.
   typedef struct packed {
      logic [1:0]  grant;
      logic [15:0] data;
      logic [7:0]  user;
      logic        esync;
      logic        eover;
   } exp_t;

   // One message sent alone by one requester, plus what it must produce.
   typedef struct {
      int          ch;
      logic [15:0] base;
      int          n;
      logic [7:0]  first;
      logic [1:0]  exp_grant;
      int          exp_sync;
      int          exp_over;
   } vec_t;

   exp_t sbq[$];
   int   checks = 0;
   int   passes = 0;
   int   n_sync = 0;
   int   n_over = 0;
   logic tog_run;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [7:0] word_user(input int i, input logic [7:0] first);
      return (i == 0) ? first : {7'(i), TUSER_DATA_SYNC};
   endfunction

   task automatic drive(input int ch, input logic v, input logic [15:0] d,
                        input logic [7:0] u, input logic l);
      if (ch == 0) begin
         s0_tvalid = v; s0_tdata = d; s0_tuser = u; s0_tlast = l;
      end else begin
         s1_tvalid = v; s1_tdata = d; s1_tuser = u; s1_tlast = l;
      end
   endtask

   // Source side: present each word and hold it until it is accepted.
   task automatic send_msg(input int ch, input logic [15:0] base, input int n,
                           input logic [7:0] first);
      logic rdy;
      int   t;
      for (int i = 0; i < n; i++) begin
         drive(ch, 1'b1, base + 16'(i), word_user(i, first), (i == n - 1));
         rdy = 1'b0;
         t   = 0;
         while (!rdy && t < 2000) begin
            @(negedge aclk);
            t++;
            rdy = (ch == 0) ? s0_tready : s1_tready;
         end
         if (!rdy) begin
            checks++;
            $display("FAIL ch%0d_accept_timeout: word %0d not accepted in %0d cycles", ch, i, t);
         end
         @(posedge aclk);
         #1;
      end
      drive(ch, 1'b0, 16'h0, 8'h0, 1'b0);
   endtask

   // Reference model: the cap splits a message; each grant's first word and
   // the cap word carry their error pulses.
   task automatic expect_msg(input logic [1:0] g, input logic [15:0] base, input int n,
                             input logic [7:0] first);
      exp_t       e;
      logic       last;
      logic [7:0] u;
      int         p;
      p = 0;
      for (int i = 0; i < n; i++) begin
         u       = word_user(i, first);
         last    = (i == n - 1);
         e.grant = g;
         e.data  = base + 16'(i);
         e.user  = u;
         e.esync = (p == 0) && (u[0] == TUSER_DATA_SYNC);
         e.eover = (p == MAX_WORDS - 1) && !last;
         sbq.push_back(e);
         p = (last || p == MAX_WORDS - 1) ? 0 : p + 1;
      end
   endtask

   task automatic monitor();
      exp_t       e;
      logic [1:0] er;
      forever begin
         @(negedge aclk);
         if (err_sync)    n_sync++;
         if (err_overlen) n_over++;
         er = (grant == 2'b01) ? {1'b0, m_tready} :
              (grant == 2'b10) ? {m_tready, 1'b0} : 2'b00;
         check("route",
               {grant == 2'b11, s1_tready, s0_tready,
                (grant == 2'b00) ? {m_tvalid, m_tdata, m_tuser, err_sync, err_overlen} : 27'h0},
               {1'b0, er, 27'h0});
         if (m_tvalid && m_tready) begin
            if (sbq.size() == 0) begin
               checks++;
               $display("FAIL unexpected_word: got data %h user %h grant %b, nothing expected",
                        m_tdata, m_tuser, grant);
            end else begin
               e = sbq.pop_front();
               check("word", {grant, m_tdata, m_tuser, err_sync, err_overlen}, e);
            end
         end
      end
   endtask

   task automatic do_reset();
      arstn = 1'b0;
      repeat (3) begin
         @(negedge aclk);
         check("reset_outputs",
               {m_tdata, m_tuser, m_tvalid, s0_tready, s1_tready, grant, busy, err_overlen, err_sync},
               32'h0);
      end
      @(posedge aclk);
      #1;
      arstn = 1'b1;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((sbq.size() != 0 || busy) && t < 3000) begin
         @(negedge aclk);
         t++;
      end
      if (t >= 3000) begin
         checks++;
         $display("FAIL idle_timeout: %0d words still expected, busy=%b", sbq.size(), busy);
      end
   endtask

   initial begin
      vec_t       vecs[6];
      logic       pat[4];
      int         n;
      int         k;
      int         sb;
      int         ob;

      // ch, base, words, first tuser, grant, err_sync pulses, err_overlen pulses
      vecs[0] = '{0, 16'h3000,  3, 8'h01, 2'b01, 0, 0};
      vecs[1] = '{1, 16'h4000, 40, 8'h03, 2'b10, 1, 1};  // cap splits 33 + 7 (data-sync restart)
      vecs[2] = '{0, 16'h5000,  1, 8'h00, 2'b01, 1, 0};  // data sync on first word
      vecs[3] = '{1, 16'h6000, 33, 8'hA5, 2'b10, 0, 0};  // exactly at the cap with tlast
      vecs[4] = '{0, 16'h7000, 34, 8'h01, 2'b01, 1, 1};  // one word over the cap
      vecs[5] = '{1, 16'h8000,  2, 8'h00, 2'b10, 1, 0};
      pat     = '{1'b1, 1'b0, 1'b0, 1'b1};

      drive(0, 1'b1, 16'hDEAD, 8'h01, 1'b1);   // a request pending during reset
      drive(1, 1'b0, 16'h0, 8'h0, 1'b0);
      m_tready = 1'b1;
      tog_run  = 1'b0;
      fork
         monitor();
      join_none

      #1;
      do_reset();
      drive(0, 1'b0, 16'h0, 8'h0, 1'b0);
      @(negedge aclk);
      @(negedge aclk);
      check("idle_after_reset", {busy, grant}, 3'b000);

      // Single message: first-word latency, then exact gap before the next grant.
      @(posedge aclk);
      #1;
      expect_msg(2'b01, 16'h1100, 3, 8'h01);
      fork
         send_msg(0, 16'h1100, 3, 8'h01);
         begin
            n = 0;
            do begin
               @(negedge aclk);
               n++;
            end while (!m_tvalid && n < 50);
            check("first_word_latency", n - 1, 2);
            check("busy_grant_first_word", {busy, grant}, 3'b101);
         end
      join
      expect_msg(2'b01, 16'h1200, 2, 8'h01);
      fork
         send_msg(0, 16'h1200, 2, 8'h01);
         begin
            n = 0;
            do begin
               @(negedge aclk);
               n++;
               if (n == 100) check("mid_gap_state", {busy, grant, s0_tready}, 4'b1000);
            end while (grant == 2'b00 && n < 1000);
            // gap, one IDLE cycle, one ARB cycle
            check("gap_cycles", n - 1, GAP_CYCLES + 2);
         end
      join
      wait_idle();

      // Both requesters continuously valid: whole messages alternate from pointer 0.
      do_reset();
      expect_msg(2'b01, 16'hA000, 2, 8'h01);
      expect_msg(2'b10, 16'hB000, 2, 8'h01);
      expect_msg(2'b01, 16'hA100, 2, 8'h01);
      expect_msg(2'b10, 16'hB100, 2, 8'h01);
      fork
         begin
            send_msg(0, 16'hA000, 2, 8'h01);
            send_msg(0, 16'hA100, 2, 8'h01);
         end
         begin
            send_msg(1, 16'hB000, 2, 8'h01);
            send_msg(1, 16'hB100, 2, 8'h01);
         end
      join
      wait_idle();

      // Table of lone messages.
      for (int v = 0; v < 6; v++) begin
         sb = n_sync;
         ob = n_over;
         expect_msg(vecs[v].exp_grant, vecs[v].base, vecs[v].n, vecs[v].first);
         send_msg(vecs[v].ch, vecs[v].base, vecs[v].n, vecs[v].first);
         wait_idle();
         check($sformatf("vec%0d_sync_pulses", v), n_sync - sb, vecs[v].exp_sync);
         check($sformatf("vec%0d_overlen_pulses", v), n_over - ob, vecs[v].exp_over);
      end

      // m_tready stalls during XFER; the cap still lands on the 33rd handshake.
      sb = n_over;
      expect_msg(2'b01, 16'hC000, 35, 8'h01);
      tog_run = 1'b1;
      fork
         begin
            send_msg(0, 16'hC000, 35, 8'h01);
            tog_run = 1'b0;
         end
         begin
            k = 0;
            while (tog_run) begin
               m_tready = pat[k % 4];
               k++;
               @(posedge aclk);
               #1;
            end
            m_tready = 1'b1;
         end
      join
      wait_idle();
      check("stall_overlen_pulses", n_over - sb, 1);

      // Reset in the middle of a stalled grant; pointer was 1 (last message from s0).
      m_tready = 1'b0;
      drive(0, 1'b1, 16'hD000, 8'h01, 1'b1);
      n = 0;
      do begin
         @(negedge aclk);
         n++;
      end while (grant == 2'b00 && n < 20);
      check("pre_reset_grant", grant, 2'b01);
      @(posedge aclk);
      #1;
      drive(1, 1'b1, 16'hE000, 8'h01, 1'b1);
      m_tready = 1'b1;
      do_reset();
      expect_msg(2'b01, 16'hD000, 1, 8'h01);
      expect_msg(2'b10, 16'hE000, 1, 8'h01);
      fork
         send_msg(0, 16'hD000, 1, 8'h01);
         send_msg(1, 16'hE000, 1, 8'h01);
      join
      wait_idle();
      check("scoreboard_drained", sbq.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
